// File: rtl/pipelined_register_file.sv
// General-purpose register file with one synchronous write port, two combinational
// read ports, optional write-to-read bypass and a per-register pending-write scoreboard.
module pipelined_register_file #(
    parameter int DATA_W           = 8,
    parameter int NUM_REGS         = 8,
    parameter int ADDR_W           = 3,
    parameter int RESET_INIT_INDEX = 1,
    parameter int BYPASS           = 1,
    parameter int R0_ZERO          = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   Read_Reg_Num_1,
    input  logic [ADDR_W-1:0]   Read_Reg_Num_2,
    output logic [DATA_W-1:0]   Read_Data_1,
    output logic [DATA_W-1:0]   Read_Data_2,
    output logic                Read_Busy_1,
    output logic                Read_Busy_2,
    input  logic [ADDR_W-1:0]   Write_Reg_Num,
    input  logic [DATA_W-1:0]   Write_Data,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   Issue_Reg_Num,
    input  logic                Issue_Valid,
    output logic                Issue_Ready,
    output logic [NUM_REGS-1:0] Busy_Vector
);

    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_fire;
    logic                set_fire;

    // A "live" index names a real, writable register (in range and not a hardwired r0).
    function automatic logic is_live(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < NUM_REGS_W) && !((R0_ZERO != 0) && (idx == '0));
    endfunction

    assign wr_fire  = Reset && RegWrite && is_live(Write_Reg_Num);

    // A busy target may still issue when its producer writes back this very cycle.
    assign Issue_Ready = Reset && (!is_live(Issue_Reg_Num) || !busy_q[Issue_Reg_Num] ||
                                   (RegWrite && (Write_Reg_Num == Issue_Reg_Num)));
    assign set_fire    = Issue_Valid && Issue_Ready && is_live(Issue_Reg_Num);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_nxt[i] = busy_q[i];
            if (wr_fire && (Write_Reg_Num == ADDR_W'(i)))
                busy_nxt[i] = 1'b0;
            // Set is applied last so a new producer wins over the retiring one.
            if (set_fire && (Issue_Reg_Num == ADDR_W'(i)))
                busy_nxt[i] = 1'b1;
        end
    end

    // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            // NOTE: the array is reset explicitly because software relies on the index init values.
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (RESET_INIT_INDEX != 0) ? DATA_W'(i) : '0;
            busy_q <= '0;
        end else begin
            if (wr_fire)
                regs[Write_Reg_Num] <= Write_Data;
            busy_q <= busy_nxt;
        end
    end

    assign Busy_Vector = busy_q;

    for (genvar p = 0; p < 2; p++) begin : g_read
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign idx = (p == 0) ? Read_Reg_Num_1 : Read_Reg_Num_2;

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (is_live(idx)) begin
                if ((BYPASS != 0) && wr_fire && (Write_Reg_Num == idx)) begin
                    data = Write_Data;
                end else begin
                    data = regs[idx];
                    busy = busy_q[idx];
                end
            end
        end
    end

    assign Read_Data_1 = g_read[0].data;
    assign Read_Data_2 = g_read[1].data;
    assign Read_Busy_1 = g_read[0].busy;
    assign Read_Busy_2 = g_read[1].busy;

endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed bench: default config plus a no-bypass copy and an R0_ZERO / 6-register copy,
// all driven by the same stimulus.
module tb_pipelined_register_file;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Read_Reg_Num_1, Read_Reg_Num_2, Write_Reg_Num, Issue_Reg_Num;
    logic [7:0] Write_Data;
    logic       RegWrite, Issue_Valid;

    logic [7:0] d_rd1, d_rd2, d_vec;
    logic       d_b1, d_b2, d_rdy;
    logic [7:0] nb_rd1, nb_rd2, nb_vec;
    logic       nb_b1, nb_b2, nb_rdy;
    logic [7:0] z_rd1, z_rd2;
    logic [5:0] z_vec;
    logic       z_b1, z_b2, z_rdy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    pipelined_register_file dut (
        .Clk(Clk), .Reset(Reset),
        .Read_Reg_Num_1(Read_Reg_Num_1), .Read_Reg_Num_2(Read_Reg_Num_2),
        .Read_Data_1(d_rd1), .Read_Data_2(d_rd2), .Read_Busy_1(d_b1), .Read_Busy_2(d_b2),
        .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data), .RegWrite(RegWrite),
        .Issue_Reg_Num(Issue_Reg_Num), .Issue_Valid(Issue_Valid), .Issue_Ready(d_rdy),
        .Busy_Vector(d_vec)
    );

    pipelined_register_file #(.BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset),
        .Read_Reg_Num_1(Read_Reg_Num_1), .Read_Reg_Num_2(Read_Reg_Num_2),
        .Read_Data_1(nb_rd1), .Read_Data_2(nb_rd2), .Read_Busy_1(nb_b1), .Read_Busy_2(nb_b2),
        .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data), .RegWrite(RegWrite),
        .Issue_Reg_Num(Issue_Reg_Num), .Issue_Valid(Issue_Valid), .Issue_Ready(nb_rdy),
        .Busy_Vector(nb_vec)
    );

    pipelined_register_file #(.NUM_REGS(6), .R0_ZERO(1)) dut_z (
        .Clk(Clk), .Reset(Reset),
        .Read_Reg_Num_1(Read_Reg_Num_1), .Read_Reg_Num_2(Read_Reg_Num_2),
        .Read_Data_1(z_rd1), .Read_Data_2(z_rd2), .Read_Busy_1(z_b1), .Read_Busy_2(z_b2),
        .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data), .RegWrite(RegWrite),
        .Issue_Reg_Num(Issue_Reg_Num), .Issue_Valid(Issue_Valid), .Issue_Ready(z_rdy),
        .Busy_Vector(z_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; RegWrite = 1'b0; Issue_Valid = 1'b0;
        Read_Reg_Num_1 = '0; Read_Reg_Num_2 = '0; Write_Reg_Num = '0; Issue_Reg_Num = '0;
        Write_Data = '0;
        tick();
        Reset = 1'b1;

        // Reset values through both ports; dut_z returns 0 for r0 and out-of-range r6/r7.
        for (int i = 0; i < 8; i++) begin
            Read_Reg_Num_1 = 3'(i);
            Read_Reg_Num_2 = 3'(i);
            #1;
            check($sformatf("init_p1_r%0d", i), d_rd1, i);
            check($sformatf("init_p2_r%0d", i), d_rd2, i);
            check($sformatf("z_init_r%0d", i), z_rd1, (i < 6) ? i : 0);
        end
        check("init_vec", d_vec, 8'h00);
        check("init_ready", d_rdy, 1);

        // Write r3 with bypass visible the same cycle; no-bypass copy shows old value.
        RegWrite = 1'b1; Write_Reg_Num = 3'd3; Write_Data = 8'hA5; Read_Reg_Num_1 = 3'd3;
        #1;
        check("bypass_r3", d_rd1, 8'hA5);
        check("nobypass_r3_pre", nb_rd1, 8'h03);
        tick();
        RegWrite = 1'b0;
        #1;
        check("stored_r3", d_rd1, 8'hA5);
        check("nobypass_r3_post", nb_rd1, 8'hA5);

        // Issue r5, then a WAW re-issue must stall; writeback clears it.
        Issue_Valid = 1'b1; Issue_Reg_Num = 3'd5; Read_Reg_Num_2 = 3'd5;
        #1;
        check("issue_r5_ready", d_rdy, 1);
        tick();
        check("vec_r5", d_vec, 8'h20);
        check("busy2_r5", d_b2, 1);
        check("waw_stall", d_rdy, 0);
        tick();
        check("vec_r5_hold", d_vec, 8'h20);
        Issue_Valid = 1'b0; RegWrite = 1'b1; Write_Reg_Num = 3'd5; Write_Data = 8'h3C;
        #1;
        check("bypass_r5_data", d_rd2, 8'h3C);
        check("bypass_r5_busy", d_b2, 0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("vec_r5_clear", d_vec, 8'h00);
        check("stored_r5", d_rd2, 8'h3C);
        check("busy2_r5_clear", d_b2, 0);

        // r2 busy; writeback and re-issue on the same edge: set wins.
        Issue_Valid = 1'b1; Issue_Reg_Num = 3'd2;
        tick();
        check("vec_r2", d_vec, 8'h04);
        RegWrite = 1'b1; Write_Reg_Num = 3'd2; Write_Data = 8'h5A;
        #1;
        check("coincide_ready", d_rdy, 1);
        tick();
        RegWrite = 1'b0; Issue_Valid = 1'b0; Read_Reg_Num_1 = 3'd2;
        #1;
        check("coincide_vec", d_vec, 8'h04);
        check("coincide_data", d_rd1, 8'h5A);
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        #1;
        check("r2_cleared", d_vec, 8'h00);

        // Hardwired r0 on dut_z; plain r0 on dut takes data and the set wins.
        RegWrite = 1'b1; Write_Reg_Num = 3'd0; Write_Data = 8'hFF;
        Issue_Valid = 1'b1; Issue_Reg_Num = 3'd0; Read_Reg_Num_1 = 3'd0;
        #1;
        check("z_r0_data", z_rd1, 8'h00);
        check("z_r0_busy", z_b1, 0);
        check("z_r0_ready", z_rdy, 1);
        tick();
        RegWrite = 1'b0; Issue_Valid = 1'b0;
        #1;
        check("z_r0_vec", z_vec, 6'h00);
        check("z_r0_stored", z_rd1, 8'h00);
        check("r0_vec", d_vec, 8'h01);
        check("r0_data", d_rd1, 8'hFF);
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        #1;
        check("r0_cleared", d_vec, 8'h00);

        // Out-of-range r7 on the 6-register copy: reads 0, write ignored.
        RegWrite = 1'b1; Write_Reg_Num = 3'd7; Write_Data = 8'hEE; Read_Reg_Num_2 = 3'd7;
        #1;
        check("z_r7_bypass", z_rd2, 8'h00);
        check("z_r7_busy", z_b2, 0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("z_r7_stored", z_rd2, 8'h00);
        check("r7_stored", d_rd2, 8'hEE);

        // Mid-operation reset discards pending bits; the concurrent writeback is ignored.
        Issue_Valid = 1'b1; Issue_Reg_Num = 3'd1;
        tick();
        Issue_Reg_Num = 3'd4;
        tick();
        Issue_Valid = 1'b0;
        #1;
        check("vec_r1_r4", d_vec, 8'h12);
        check("z_vec_r1_r4", z_vec, 6'h12);
        Reset = 1'b0; RegWrite = 1'b1; Write_Reg_Num = 3'd4; Write_Data = 8'h77;
        Read_Reg_Num_1 = 3'd4; Read_Reg_Num_2 = 3'd1;
        #1;
        check("reset_no_bypass", d_rd1, 8'h04);
        check("reset_ready_low", d_rdy, 0);
        tick();
        Reset = 1'b1; RegWrite = 1'b0;
        #1;
        check("post_reset_vec", d_vec, 8'h00);
        check("post_reset_r4", d_rd1, 8'h04);
        check("post_reset_r1", d_rd2, 8'h01);
        check("z_post_reset_vec", z_vec, 6'h00);
        Read_Reg_Num_1 = 3'd3; Read_Reg_Num_2 = 3'd7;
        #1;
        check("post_reset_r3", d_rd1, 8'h03);
        check("post_reset_r7", d_rd2, 8'h07);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
